// File: rtl/tsm_pkg.sv
// Shared types and defaults for the end-of-test status monitor.
package tsm_pkg;

   localparam int REG_IDX_W      = 5;
   localparam int DEF_DONE_REG   = 26;
   localparam int DEF_RESULT_REG = 27;
   localparam int DEF_CODE_REG   = 28;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_VERDICT = 2'd2,
      ST_TIMEOUT = 2'd3
   } tsm_state_e;

endpackage

// File: rtl/test_status_monitor_if.sv
// Snooped register-file writeback bus, one lane per hart.
// Hart h occupies rf_waddr_i[h] / rf_wdata_i[h] (flat bits [5h+4:5h] and [XLEN*h+XLEN-1:XLEN*h]).
interface test_status_monitor_if #(
   parameter int NUM_HARTS = 1,
   parameter int XLEN      = 32
);
   logic [NUM_HARTS-1:0]                           rf_we_i;
   logic [NUM_HARTS-1:0][tsm_pkg::REG_IDX_W-1:0]   rf_waddr_i;
   logic [NUM_HARTS-1:0][XLEN-1:0]                 rf_wdata_i;

   modport master (output rf_we_i, rf_waddr_i, rf_wdata_i);
   modport slave  (input  rf_we_i, rf_waddr_i, rf_wdata_i);
endinterface

// File: rtl/tsm_hart_shadow.sv
// Per-hart shadow of the done/result/code registers, fed by one writeback port.
// CODE_EN=0 skips the code register for harts whose code is never reported.
module tsm_hart_shadow
   import tsm_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DONE_REG   = DEF_DONE_REG,
   parameter int RESULT_REG = DEF_RESULT_REG,
   parameter int CODE_REG   = DEF_CODE_REG,
   parameter bit CODE_EN    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] waddr,
   input  logic [XLEN-1:0]      wdata,
   output logic                 done_seen,
   output logic [XLEN-1:0]      result,
   output logic [XLEN-1:0]      code
);
   localparam logic [REG_IDX_W-1:0] DONE_IDX   = REG_IDX_W'(DONE_REG);
   localparam logic [REG_IDX_W-1:0] RESULT_IDX = REG_IDX_W'(RESULT_REG);
   localparam logic [REG_IDX_W-1:0] CODE_IDX   = REG_IDX_W'(CODE_REG);

   // x0 is hardwired zero in the core, so writes to it never count
   logic wr;
   assign wr = we && (waddr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_seen <= 1'b0;
         result    <= '0;
      end else if (clr) begin
         done_seen <= 1'b0;
         result    <= '0;
      end else if (wr) begin
         if (waddr == DONE_IDX && wdata == XLEN'(1)) done_seen <= 1'b1;
         if (waddr == RESULT_IDX)                    result    <= wdata;
      end
   end

   generate
      if (CODE_EN) begin : g_code
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                        code <= '0;
            else if (clr)                      code <= '0;
            else if (wr && waddr == CODE_IDX)  code <= wdata;
         end
      end else begin : g_no_code
         assign code = '0;
      end
   endgenerate

endmodule

// File: rtl/test_status_monitor.sv
// End-of-test monitor: snoops hart writebacks and registers a pass/fail/timeout verdict.
// Optional: define TSM_TIMEOUT_EN to build the RUN-state timeout counter and TIMEOUT state.
module test_status_monitor
   import tsm_pkg::*;
#(
   parameter int NUM_HARTS      = 1,
   parameter int XLEN           = 32,
   parameter int DONE_REG       = DEF_DONE_REG,
   parameter int RESULT_REG     = DEF_RESULT_REG,
   parameter int CODE_REG       = DEF_CODE_REG,
   parameter int DRAIN_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int CNT_W          = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   test_status_monitor_if.slave  wb,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  timeout_o,
   output logic [NUM_HARTS-1:0]  fail_mask_o,
   output logic [XLEN-1:0]       code_o,
   output logic [CNT_W-1:0]      cycle_cnt_o
);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   tsm_state_e state_q, state_d;

   logic [NUM_HARTS-1:0]            done_seen;
   logic [NUM_HARTS-1:0]            res_ok;
   logic [NUM_HARTS-1:0][XLEN-1:0]  result;
   logic [NUM_HARTS-1:0][XLEN-1:0]  code_all;
   logic                            all_done;
   logic                            run_tc;
   logic                            drain_tc;
   logic [DRN_W-1:0]                drain_cnt;
   logic                            unused_code_bits;

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      tsm_hart_shadow #(
         .XLEN       (XLEN),
         .DONE_REG   (DONE_REG),
         .RESULT_REG (RESULT_REG),
         .CODE_REG   (CODE_REG),
         .CODE_EN    (h == 0)
      ) u_shadow (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr       (clr_i),
         .we        (wb.rf_we_i[h]),
         .waddr     (wb.rf_waddr_i[h]),
         .wdata     (wb.rf_wdata_i[h]),
         .done_seen (done_seen[h]),
         .result    (result[h]),
         .code      (code_all[h])
      );
      assign res_ok[h] = (result[h] == XLEN'(1));
   end

   assign all_done         = &done_seen;
   assign code_o           = code_all[0];
   assign unused_code_bits = ^code_all;
   assign drain_tc         = (state_q == ST_DRAIN) && (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));

`ifdef TSM_TIMEOUT_EN
   localparam int RUN_W = $clog2(TIMEOUT_CYCLES);
   logic [RUN_W-1:0] run_cnt;

   assign run_tc = (state_q == ST_RUN) && (run_cnt == RUN_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           run_cnt <= '0;
      else if (clr_i || state_q != ST_RUN)  run_cnt <= '0;
      else if (!run_tc)                     run_cnt <= run_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          timeout_o <= 1'b0;
      else if (clr_i)                                      timeout_o <= 1'b0;
      else if (state_q == ST_RUN && state_d == ST_TIMEOUT) timeout_o <= 1'b1;
   end
`else
   assign run_tc    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // all-done is tested before the timeout terminal count so DRAIN wins a tie
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (all_done)    state_d = ST_DRAIN;
            else if (run_tc) state_d = ST_TIMEOUT;
         end
         ST_DRAIN: if (drain_tc) state_d = ST_VERDICT;
         default: ;
      endcase
      if (clr_i) state_d = ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         drain_cnt <= '0;
      end else begin
         state_q   <= state_d;
         drain_cnt <= (state_q == ST_DRAIN && !clr_i) ? drain_cnt + 1'b1 : '0;
      end
   end

   // Verdict samples the shadows one edge after VERDICT is entered, so a
   // result written on the final DRAIN edge still counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_mask_o <= '0;
      end else if (clr_i) begin
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_mask_o <= '0;
      end else if (state_q == ST_VERDICT && !done_o) begin
         done_o      <= 1'b1;
         pass_o      <= &res_ok;
         fail_mask_o <= ~res_ok;
      end else if (state_q == ST_RUN && state_d == ST_TIMEOUT) begin
         done_o      <= 1'b1;
         pass_o      <= 1'b0;
         fail_mask_o <= '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cycle_cnt_o <= '0;
      else if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 1'b1;
   end

endmodule

// File: doc/test_status_monitor.md
# test_status_monitor

Synthesizable end-of-test monitor that snoops the register-file writeback port of one or more rvcore harts and decides pass/fail/timeout in hardware. It replaces the testbench's hierarchical `wait` on `regs[26]`/`regs[27]` with registered status outputs. The same block serves the simulation top and FPGA builds, which drive `done_o`/`pass_o` onto LEDs. It sits in `soc` beside the core(s) and observes only; it never stalls or drives the core.

## Interface
- `NUM_HARTS`, 1: number of snooped writeback ports.
- `XLEN`, 32: register width.
- `DONE_REG`, 26: done-flag register index (s10).
- `RESULT_REG`, 27: result register index (s11); 1 means pass.
- `CODE_REG`, 28: diagnostic code register index (t3).
- `DRAIN_CYCLES`, 50: settle cycles between all-done and the verdict (≥1).
- `TIMEOUT_CYCLES`, 5000: RUN-state cycle limit (≥2).
- `CNT_W`, 32: width of the cycle counter.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr_i` in 1: synchronous restart. Returns the block to RUN and clears all state except the cycle counter.
- `rf_we_i` in NUM_HARTS: per-hart writeback enable.
- `rf_waddr_i` in 5*NUM_HARTS: per-hart write index. Hart h uses bits [5h+4:5h].
- `rf_wdata_i` in XLEN*NUM_HARTS: per-hart write data.
- `done_o` out 1: verdict valid (sticky).
- `pass_o` out 1: all harts passed. Valid only with `done_o`.
- `timeout_o` out 1: RUN exceeded its limit (sticky).
- `fail_mask_o` out NUM_HARTS: bit h is set when hart h's result ≠ 1 at the verdict.
- `code_o` out XLEN: hart 0's last CODE_REG write.
- `cycle_cnt_o` out CNT_W: cycles since reset.

## Operation
- Per hart, shadow registers `done_seen` (sticky), `result`, and `code` are updated on `rf_we_i[h]` when `rf_waddr_i` matches the relevant index.
  - Writes to index 0 are ignored.
  - `done_seen` sets only when DONE_REG is written with exactly 1. A later write of another value does not clear it.
  - `result` and `code` always mirror the latest write.
- FSM states and transitions:
  - RUN → DRAIN when every `done_seen` is 1.
  - RUN → TIMEOUT when the RUN counter reaches TIMEOUT_CYCLES-1 and not all harts are done.
  - DRAIN → VERDICT after DRAIN_CYCLES cycles. Shadows keep updating during DRAIN.
  - VERDICT and TIMEOUT are terminal until `clr_i` or reset.
- Verdict: `pass_o = &(result == 1)` across all harts, and `fail_mask_o` is the per-hart complement. Both are registered on entering VERDICT and held.
- TIMEOUT: `timeout_o=1`, `done_o=1`, `pass_o=0`, `fail_mask_o` all ones.
- `cycle_cnt_o` increments every cycle and saturates at all ones. `clr_i` does not reset it.

## Timing
- Reset values of all outputs and shadows are 0; FSM is in RUN; counters are 0.
- A write sampled at edge k is visible in the shadows after k. The FSM leaves RUN at edge k+1 if all harts are then done.
- DRAIN occupies exactly DRAIN_CYCLES clock cycles. `done_o`/`pass_o` rise at the next edge after DRAIN ends, i.e. DRAIN_CYCLES+2 edges after the completing write.
- If all-done and the timeout terminal count occur in the same cycle, DRAIN wins.
- `clr_i` takes priority over all transitions. The same-cycle writeback is discarded.
- If `rst_n` asserts mid-DRAIN, outputs drop immediately (asynchronously) and no verdict is produced.
- A multi-hart same-cycle writeback is legal; every hart updates independently.

## Configuration
- `TSM_TIMEOUT_EN` defined: the RUN counter and TIMEOUT state exist as described.
- `TSM_TIMEOUT_EN` undefined: no RUN counter is built, TIMEOUT is unreachable, `timeout_o` is tied to 0, TIMEOUT_CYCLES is ignored, and RUN waits indefinitely.

## Structure
- `tsm_pkg`: FSM state encoding (RUN, DRAIN, VERDICT, TIMEOUT), default register-index constants, and the register-index width (5).
- Sub-module `tsm_hart_shadow`: one per hart via generate. It holds `done_seen`/`result`/`code` and decodes one writeback port.
- Top level: FSM, drain/timeout counters, cycle counter, verdict reduction.

## Test plan
- Single hart: write x27=1, then x26=1 at cycle 100 → `done_o=1`, `pass_o=1`, `fail_mask_o=0` at cycle 100+DRAIN_CYCLES+2; `timeout_o=0`.
- Single hart: write x26=1 with x27=0, then x27=1 during DRAIN → pass (late result captured). Same case with x27 set to 5 during DRAIN → `pass_o=0`, `fail_mask_o=1`.
- NUM_HARTS=2: hart1 done at cycle 50, hart0 done at cycle 80, hart1 result 3 → DRAIN starts after 80, `fail_mask_o=2'b10`, `pass_o=0`.
- TIMEOUT_CYCLES=200, no done write → `timeout_o=1`, `done_o=1`, `pass_o=0` at cycle 200. With the macro undefined → no `done_o` by cycle 1000.
- Writes to x0, and x26=2 followed by x26=0 → `done_seen` stays 0; x26=1 then x26=0 → `done_seen` stays 1.
- `clr_i` pulse in VERDICT, and `rst_n` low mid-DRAIN → outputs return to 0; `cycle_cnt_o` keeps counting after `clr_i` but returns to 0 after `rst_n`.
